// File: rtl/alu32_pkg.sv
// Shared encodings, FSM states and response payload for the ALU32 execution unit.
package alu32_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;

    // Operation classes (op)
    localparam logic [OP_W-1:0] ALU_ARITH = 4'd0;
    localparam logic [OP_W-1:0] ALU_SHIFT = 4'd1;
    localparam logic [OP_W-1:0] ALU_LOGIC = 4'd2;
    localparam logic [OP_W-1:0] ALU_MUL   = 4'd3;

    // Sub-operations (op1)
    localparam logic [OP_W-1:0] ARITH_ADD = 4'd0;
    localparam logic [OP_W-1:0] ARITH_INC = 4'd1;
    localparam logic [OP_W-1:0] ARITH_SUB = 4'd2;
    localparam logic [OP_W-1:0] ARITH_DEC = 4'd3;
    localparam logic [OP_W-1:0] SHIFT_SLL = 4'd0;
    localparam logic [OP_W-1:0] SHIFT_SRL = 4'd1;
    localparam logic [OP_W-1:0] SHIFT_SRA = 4'd2;
    localparam logic [OP_W-1:0] SHIFT_SLA = 4'd3;
    localparam logic [OP_W-1:0] LOGIC_AND = 4'd0;
    localparam logic [OP_W-1:0] LOGIC_OR  = 4'd1;
    localparam logic [OP_W-1:0] LOGIC_XOR = 4'd2;
    localparam logic [OP_W-1:0] LOGIC_SWP = 4'd3;
    localparam logic [OP_W-1:0] LOGIC_NOT = 4'd4;
    localparam logic [OP_W-1:0] MUL_U     = 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] out;
        logic [DATA_W-1:0] out0;
        logic              carryout;
        logic              overflow;
        logic              zero;
        logic              n;
        logic              err;
    } alu_rsp_t;

    function automatic logic is_mul_req(input logic [OP_W-1:0] op, input logic [OP_W-1:0] op1);
        return (op == ALU_MUL) && (op1 == MUL_U);
    endfunction

endpackage

// File: rtl/alu32_mul_seq.sv
// Iterative unsigned 32x32 shift-add multiplier retiring MUL_STEP multiplier bits per cycle.
module alu32_mul_seq
    import alu32_pkg::*;
#(
    parameter int unsigned MUL_STEP = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic                done,
    output logic [2*DATA_W-1:0] product
);

    localparam int unsigned STEPS = DATA_W / MUL_STEP;
    localparam int unsigned CNT_W = 6;

    logic [2*DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    function automatic logic [2*DATA_W-1:0] partial(input logic [2*DATA_W-1:0] m,
                                                    input logic [MUL_STEP-1:0]  bits);
        logic [2*DATA_W-1:0] p;
        p = '0;
        for (int unsigned j = 0; j < MUL_STEP; j++) begin
            if (bits[j]) p = p + (m << j);
        end
        return p;
    endfunction

    // The start cycle already retires the first group of bits, so the last
    // group lands STEPS-1 cycles later and done rises with the final product.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (start) begin
            mcand_d  = {32'd0, a} << MUL_STEP;
            mplier_d = b >> MUL_STEP;
            acc_d    = partial({32'd0, a}, b[MUL_STEP-1:0]);
            cnt_d    = CNT_W'(1);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_q + partial(mcand_q, mplier_q[MUL_STEP-1:0]);
            mcand_d  = mcand_q << MUL_STEP;
            mplier_d = mplier_q >> MUL_STEP;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(STEPS - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: rtl/alu32_exec_unit.sv
// ALU32 execution unit: valid/ready request in, registered result and flags out.
module alu32_exec_unit
    import alu32_pkg::*;
#(
    parameter int unsigned MUL_STEP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [OP_W-1:0]   op1,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] out,
    output logic [DATA_W-1:0] out0,
    output logic              carryout,
    output logic              overflow,
    output logic              zero,
    output logic              N,
    output logic              rsp_err
);

    state_t   state_q, state_d;
    alu_rsp_t rsp_q, rsp_d;
    logic     req_ready_q, req_ready_d;
    logic     rsp_valid_q, rsp_valid_d;

    alu_rsp_t            res_c;
    alu_rsp_t            mul_res_c;
    logic                mul_start_c;
    logic                mul_done;
    logic [2*DATA_W-1:0] mul_product;
    logic [32:0]         sum_c;
    logic [DATA_W-1:0]   addb_c;
    logic                cin_c;
    logic [4:0]          sh_c;

    alu32_mul_seq #(.MUL_STEP(MUL_STEP)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start_c),
        .a       (in0),
        .b       (in1),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle datapath: arith, shift, logic and illegal-encoding detection
    always_comb begin
        res_c  = '0;
        sh_c   = in1[4:0];
        addb_c = in1;
        cin_c  = 1'b0;
        case (op1)
            ARITH_INC: begin addb_c = '0;         cin_c = 1'b1; end
            ARITH_SUB: begin addb_c = ~in1;       cin_c = 1'b1; end
            ARITH_DEC: begin addb_c = '1;         cin_c = 1'b0; end
            default:   begin addb_c = in1;        cin_c = 1'b0; end
        endcase
        sum_c = {1'b0, in0} + {1'b0, addb_c} + 33'(cin_c);

        case (op)
            ALU_ARITH: begin
                if (op1 <= ARITH_DEC) begin
                    res_c.out      = sum_c[31:0];
                    res_c.carryout = sum_c[32];
                    res_c.overflow = (in0[31] == addb_c[31]) && (sum_c[31] != in0[31]);
                end else begin
                    res_c.err = 1'b1;
                end
            end
            ALU_SHIFT: begin
                case (op1)
                    SHIFT_SLL: res_c.out = in0 << sh_c;
                    SHIFT_SRL: res_c.out = in0 >> sh_c;
                    SHIFT_SRA: res_c.out = 32'($signed(in0) >>> sh_c);
                    SHIFT_SLA: begin
                        res_c.out = {in0[31], 31'(in0 << sh_c)};
                        // Any bit pushed out past bit 30 must match the sign.
                        for (int i = 0; i < 31; i++) begin
                            if ((i + int'(sh_c) >= 31) && (in0[i] != in0[31])) res_c.overflow = 1'b1;
                        end
                    end
                    default: res_c.err = 1'b1;
                endcase
            end
            ALU_LOGIC: begin
                case (op1)
                    LOGIC_AND: res_c.out = in0 & in1;
                    LOGIC_OR:  res_c.out = in0 | in1;
                    LOGIC_XOR: res_c.out = in0 ^ in1;
                    LOGIC_SWP: res_c.out = {in0[15:0], in0[31:16]};
                    LOGIC_NOT: res_c.out = ~in0;
                    default:   res_c.err = 1'b1;
                endcase
            end
            default: res_c.err = 1'b1;
        endcase

        if (res_c.err) begin
            res_c     = '0;
            res_c.err = 1'b1;
        end else begin
            res_c.zero = (res_c.out == '0);
            res_c.n    = res_c.out[31];
        end
    end

    always_comb begin
        mul_res_c          = '0;
        mul_res_c.out      = mul_product[31:0];
        mul_res_c.out0     = mul_product[63:32];
        mul_res_c.overflow = (mul_product[63:32] != '0);
        mul_res_c.zero     = (mul_product == '0);
        mul_res_c.n        = mul_product[63];
    end

    // Next-state and response capture
    always_comb begin
        state_d     = state_q;
        rsp_d       = rsp_q;
        mul_start_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (is_mul_req(op, op1)) begin
                        mul_start_c = 1'b1;
                        state_d     = MUL;
                    end else begin
                        rsp_d   = res_c;
                        state_d = RESP;
                    end
                end
            end
            MUL: begin
                if (mul_done) begin
                    rsp_d   = mul_res_c;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rsp_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_q       <= rsp_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign out       = rsp_q.out;
    assign out0      = rsp_q.out0;
    assign carryout  = rsp_q.carryout;
    assign overflow  = rsp_q.overflow;
    assign zero      = rsp_q.zero;
    assign N         = rsp_q.n;
    assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_alu32_exec_unit.sv
// Directed self-checking bench for alu32_exec_unit (MUL_STEP=1 main instance, MUL_STEP=4 latency instance).
module tb_alu32_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_valid4;
    logic        req_ready, req_ready4;
    logic [3:0]  op, op1;
    logic [31:0] in0, in1;
    logic        rsp_valid, rsp_valid4;
    logic        rsp_ready;
    logic [31:0] out, out0, out_4, out0_4;
    logic        carryout, overflow, zero, n_flag, rsp_err;
    logic        carryout4, overflow4, zero4, n_flag4, rsp_err4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu32_exec_unit #(.MUL_STEP(1)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .op(op), .op1(op1), .in0(in0), .in1(in1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .out(out), .out0(out0), .carryout(carryout), .overflow(overflow),
        .zero(zero), .N(n_flag), .rsp_err(rsp_err)
    );

    alu32_exec_unit #(.MUL_STEP(4)) u_dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid4), .req_ready(req_ready4),
        .op(op), .op1(op1), .in0(in0), .in1(in1),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready),
        .out(out_4), .out0(out0_4), .carryout(carryout4), .overflow(overflow4),
        .zero(zero4), .N(n_flag4), .rsp_err(rsp_err4)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one request to the main instance and hold it for exactly the accepting edge.
    task automatic issue(input logic [3:0] o, input logic [3:0] o1,
                         input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        op = o; op1 = o1; in0 = a; in1 = b;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        in0 = 32'hDEAD_BEEF; in1 = 32'hDEAD_BEEF;
    endtask

    // Returns the consumer-side edge (relative to the accepting edge) at which rsp_valid is first seen.
    task automatic wait_rsp(output int edge_n);
        int n;
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        edge_n = n + 1;
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [3:0] o1,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e_out, input logic [31:0] e_out0,
                          input logic [4:0] e_flags, input int e_lat);
        int lat;
        issue(o, o1, a, b);
        wait_rsp(lat);
        check_eq({tag, ".lat"}, 64'(lat), 64'(e_lat));
        check_eq({tag, ".out"}, 64'(out), 64'(e_out));
        check_eq({tag, ".out0"}, 64'(out0), 64'(e_out0));
        check_eq({tag, ".flags(c,v,z,n,err)"}, 64'({carryout, overflow, zero, n_flag, rsp_err}),
                 64'(e_flags));
    endtask

    initial begin
        int lat;
        int spurious;
        rst = 1'b1; req_valid = 1'b0; req_valid4 = 1'b0; rsp_ready = 1'b1;
        op = '0; op1 = '0; in0 = '0; in1 = '0;
        #12;
        check_eq("reset.req_ready", 64'(req_ready), 64'd1);
        check_eq("reset.rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("reset.out", 64'({out0, out}), 64'd0);
        check_eq("reset.flags", 64'({carryout, overflow, zero, n_flag, rsp_err}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // flags packed as {carryout, overflow, zero, N, rsp_err}
        run_op("add",     4'd0, 4'd0, 32'h7FFF0000, 32'h7FFF0000, 32'hFFFE0000, 32'h0, 5'b01010, 1);
        run_op("sub",     4'd0, 4'd2, 32'h81111000, 32'h61010000, 32'h20101000, 32'h0, 5'b11000, 1);
        run_op("dec0",    4'd0, 4'd3, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 32'h0, 5'b00010, 1);
        run_op("incmax",  4'd0, 4'd1, 32'hFFFFFFFF, 32'h0,        32'h00000000, 32'h0, 5'b10100, 1);
        run_op("swap",    4'd2, 4'd3, 32'h56561111, 32'h0,        32'h11115656, 32'h0, 5'b00000, 1);
        run_op("sla",     4'd1, 4'd3, 32'hF0001010, 32'd2,        32'hC0004040, 32'h0, 5'b00010, 1);
        run_op("sla_ovf", 4'd1, 4'd3, 32'h40000000, 32'd1,        32'h00000000, 32'h0, 5'b01100, 1);
        run_op("srl",     4'd1, 4'd1, 32'h09000020, 32'd7,        32'h00120000, 32'h0, 5'b00000, 1);
        run_op("sra31",   4'd1, 4'd2, 32'h80000000, 32'd31,       32'hFFFFFFFF, 32'h0, 5'b00010, 1);
        run_op("not",     4'd2, 4'd4, 32'h00000000, 32'h0,        32'hFFFFFFFF, 32'h0, 5'b00010, 1);
        run_op("xorz",    4'd2, 4'd2, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 32'h0, 5'b00100, 1);
        run_op("mul",     4'd3, 4'd0, 32'h40000000, 32'h00000008, 32'h00000000, 32'h2, 5'b01000, 33);
        run_op("mulmax",  4'd3, 4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 5'b01010, 33);
        run_op("mulzero", 4'd3, 4'd0, 32'h00000000, 32'h00000005, 32'h00000000, 32'h0, 5'b00100, 33);
        run_op("ill_op",  4'd5, 4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h0, 5'b00001, 1);
        run_op("ill_log", 4'd2, 4'd5, 32'hFFFFFFFF, 32'h1,        32'h00000000, 32'h0, 5'b00001, 1);
        run_op("ill_mul", 4'd3, 4'd1, 32'h00000003, 32'h5,        32'h00000000, 32'h0, 5'b00001, 1);

        // Backpressure with a second request waiting on req_valid
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        issue(4'd0, 4'd0, 32'd1, 32'd2);
        wait_rsp(lat);
        check_eq("bp.lat", 64'(lat), 64'd1);
        op = 4'd0; op1 = 4'd0; in0 = 32'd10; in1 = 32'd20;
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_eq("bp.hold", 64'({rsp_valid, req_ready, out, carryout, overflow, zero, n_flag, rsp_err}),
                     64'({1'b1, 1'b0, 32'd3, 5'b00000}));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_eq("bp.release", 64'({rsp_valid, req_ready}), 64'({1'b0, 1'b1}));
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq("bp.second", 64'({rsp_valid, out}), 64'({1'b1, 32'd30}));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("bp.single_accept", 64'(req_ready), 64'd0);
        end

        // Reset in the middle of a multiply
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        issue(4'd3, 4'd0, 32'h40000000, 32'h00000008);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check_eq("rstmul.ctrl", 64'({rsp_valid, req_ready}), 64'({1'b0, 1'b1}));
        check_eq("rstmul.data", 64'({out0, out}), 64'd0);
        check_eq("rstmul.flags", 64'({carryout, overflow, zero, n_flag, rsp_err}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        spurious = 0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) spurious++;
        end
        check_eq("rstmul.no_rsp", 64'(spurious), 64'd0);
        run_op("add11", 4'd0, 4'd0, 32'd1, 32'd1, 32'd2, 32'h0, 5'b00000, 1);

        // MUL_STEP=4 latency
        @(posedge clk); #1;
        op = 4'd3; op1 = 4'd0; in0 = 32'h40000000; in1 = 32'h00000008;
        req_valid4 = 1'b1;
        @(posedge clk); #1;
        req_valid4 = 1'b0;
        lat = 0;
        while (!rsp_valid4 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check_eq("mul4.lat", 64'(lat + 1), 64'd9);
        check_eq("mul4.prod", 64'({out0_4, out_4}), 64'h0000_0002_0000_0000);
        check_eq("mul4.flags", 64'({carryout4, overflow4, zero4, n_flag4, rsp_err4}), 64'(5'b01000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu32_exec_unit.md
# alu32_exec_unit

Sequenced execution unit that serves ALU32-encoded operation requests over a valid/ready handshake and returns registered results and flags. Single-cycle classes (arithmetic, shift, logic) answer one cycle after acceptance. The multiply class runs an iterative shift-add over several cycles. It sits between an instruction issuer or bench driver and downstream consumers, and is the responder side of the op/op1/in0/in1 request interface.

## Interface
- MUL_STEP, default 1: multiplier bits retired per cycle. Legal values are 1, 2 and 4; multiply latency is 32/MUL_STEP cycles.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  a request is presented.
- req_ready  out  1  unit can accept a request; equals (state==IDLE).
- op  in  4  class: 0000 arith, 0001 shift, 0010 logic, 0011 multiply.
- op1  in  4  sub-operation within the class.
- in0, in1  in  32  operands.
- rsp_valid  out  1  a response is held on the outputs.
- rsp_ready  in  1  consumer takes the response.
- out  out  32  result; low word for multiply.
- out0  out  32  high word for multiply; 0 for all other classes.
- carryout, overflow, zero, N  out  1 each  status flags.
- rsp_err  out  1  illegal op/op1 encoding.

## Operation
- Arith sub-operations (op1 selects):
  - 0 add: in0+in1
  - 1 inc: in0+1
  - 2 sub: in0+~in1+1
  - 3 dec: in0-1, computed as in0+FFFFFFFF
  - carryout is bit 32 of the 33-bit sum.
  - overflow is the two's-complement signed overflow.
- Shift sub-operations (shift amount sh=in1[4:0]):
  - 0 sll
  - 1 srl
  - 2 sra
  - 3 sla: result = {in0[31], (in0<<sh)[30:0]}. overflow=1 if any bit that passes through position 30 differs from in0[31].
- Logic sub-operations:
  - 0 and
  - 1 or
  - 2 xor
  - 3 swap: {in0[15:0], in0[31:16]}
  - 4 not: ~in0
- Multiply, op1=0: unsigned 32x32 producing 64 bits, {out0,out}. overflow=(out0!=0); carryout=0.
- Common flags:
  - zero: the full result is 0. For multiply this checks all 64 bits.
  - N: out[31] for non-multiply; out0[31] for multiply.
  - carryout and overflow are 0 wherever not defined above.
- Illegal encodings: any op above 0011, or any op1 not listed above. Response: rsp_err=1, all data and flag outputs 0, single-cycle latency.
- FSM states and transitions:
  - IDLE: on accept, a multiply request goes to MUL; any other request computes, registers its result and goes to RESP.
  - MUL: load multiplicand and multiplier and clear the accumulator and counter. Each cycle, add the partial product of the next MUL_STEP multiplier bits and shift. After 32/MUL_STEP cycles, register the result and go to RESP.
  - RESP: rsp_valid=1. When rsp_ready=1, return to IDLE.

## Timing
- Acceptance: a request is accepted on the rising edge where req_valid && req_ready. Operands are captured on that edge; inputs are ignored afterwards.
- Single-cycle latency: accepted at edge T, rsp_valid=1 from edge T+1.
- Multiply latency: rsp_valid=1 from edge T+1+32/MUL_STEP, i.e. T+33 for the default.
- No overlap: req_ready=0 in MUL and RESP, including the cycle in which the response is consumed. The next accept is possible at the earliest one cycle after the rsp_ready handshake.
- Backpressure: with rsp_ready low, all response outputs are held stable indefinitely.
- Reset values (asynchronous): state=IDLE, req_ready=1, rsp_valid=0, out=out0=0, all flags 0, rsp_err=0, multiply datapath registers 0.
- Reset mid-MUL or mid-RESP: the operation is abandoned with no response. The unit resumes in IDLE once reset deasserts.
- req_valid held high across a response: exactly one accept per IDLE visit, never a double capture.

## Structure
- Shared package `alu32_pkg`:
  - op class constants ALU_ARITH, ALU_SHIFT, ALU_LOGIC, ALU_MUL
  - op1 sub-operation constants
  - FSM state enum: IDLE, MUL, RESP
- Sub-module `alu32_mul_seq`: the iterative multiplier. Interface is start, a, b → done, product[63:0], parameterised by MUL_STEP.
- The top level holds the FSM, the combinational single-cycle datapath, the flag logic and the response registers.

## Test plan
- Add 7FFF0000+7FFF0000: out=FFFE0000, overflow=1, carryout=0, N=1, zero=0, rsp_valid at T+1.
- Sub 81111000-61010000: out=20101000, overflow=1, carryout=1. Dec of 00000000: out=FFFFFFFF, carryout=0, N=1.
- Swap 56561111: out=11115656. SLA F0001010 by 2: out=C0004040, overflow=0. SRL 09000020 by 7: out=00120000.
- Multiply 40000000×00000008 with MUL_STEP=1:
  - out=00000000, out0=00000002, overflow=1, zero=0.
  - rsp_valid exactly at T+33, and at T+9 with MUL_STEP=4.
- Backpressure and illegal encoding:
  - Hold rsp_ready=0 for 10 cycles with req_valid=1: outputs are stable, req_ready=0, and exactly one later accept occurs.
  - op=0101 returns rsp_err=1 with all outputs 0.
- Assert rst at cycle 10 of a multiply: all outputs return to their reset values immediately. A following add 1+1 returns 00000002 at T+1.
